// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loader AXI4-Lite write master.
package weight_loader_pkg;

  localparam int unsigned NUM_SYNAPSES_DEF = 73288;
  localparam int unsigned IDX_W_DEF        = 17;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam logic [31:0] BASE_ADDR_DEF    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Weights occupy the low half-word of each 32-bit memory word.
  localparam logic [3:0] WSTRB_WEIGHT = 4'b0011;

endpackage

// File: rtl/weight_loader_sat_counter.sv
// Saturating status counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/weight_loader.sv
// AXI4-Lite write master: one single-beat write per (index, weight) record,
// local rejection of out-of-range indices, and OKAY/error statistics.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned NUM_SYNAPSES = NUM_SYNAPSES_DEF,
  parameter int unsigned IDX_W        = IDX_W_DEF,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IDX_W-1:0] s_index,
  input  logic [15:0]      s_weight,
  input  logic             s_last,
  input  logic             clr_stats,
  output logic [31:0]      m_axi_awaddr,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] err_count
);

  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        wr_inc;
  logic        err_inc;
  logic        in_range;
  logic        aw_ok;
  logic        w_ok;

  assign in_range = 32'(s_index) < NUM_SYNAPSES;
  // A channel is finished once its valid is low or its handshake happens now.
  assign aw_ok    = !awvalid_q || m_axi_awready;
  assign w_ok     = !wvalid_q || m_axi_wready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    done_d    = 1'b0;
    wr_inc    = 1'b0;
    err_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (in_range) begin
            state_d   = ISSUE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR + 32'({s_index, 2'b00});
            wdata_d   = {16'h0000, s_weight};
            last_d    = s_last;
          end else begin
            err_inc = 1'b1;
            done_d  = s_last;
          end
        end
      end
      ISSUE: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          done_d   = last_q;
          if (m_axi_bresp == RESP_OKAY) wr_inc  = 1'b1;
          else                          err_inc = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_inc),
    .clr   (clr_stats),
    .count (write_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clr_stats),
    .count (err_count)
  );

  assign s_ready       = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = WSTRB_WEIGHT;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: AXI4-Lite slave/memory model with per-record stalls,
// plus a record-level model of counters, done pulses and memory contents.
module tb_weight_loader;

  localparam int unsigned NUM = 73288;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [16:0] s_index;
  logic [15:0] s_weight;
  logic        s_last;
  logic        clr_stats;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        busy;
  logic        done;
  logic [15:0] write_count;
  logic [15:0] err_count;

  weight_loader dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_index       (s_index),
    .s_weight      (s_weight),
    .s_last        (s_last),
    .clr_stats     (clr_stats),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .busy          (busy),
    .done          (done),
    .write_count   (write_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration, changed only while no record is in flight
  int         aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [1:0] bresp_cfg = 2'b00;

  // Slave state and observation counters
  int          aw_wait, w_wait, b_wait;
  bit          got_aw, got_w, b_pend;
  logic [31:0] cap_addr, cap_data;
  logic [15:0] mem [logic [31:0]];
  int          aw_hs = 0, w_hs = 0, b_hs = 0, done_cnt = 0, awv_cycles = 0, viol = 0;
  bit          aw_stall, w_stall;
  logic [31:0] prev_awaddr, prev_wdata;

  // Record-level reference model
  int          exp_wr = 0, exp_err = 0;
  logic [15:0] exp_mem [logic [31:0]];

  always @(negedge clk) begin
    m_axi_awready = m_axi_awvalid && !got_aw && (aw_wait >= aw_lat);
    m_axi_wready  = m_axi_wvalid && !got_w && (w_wait >= w_lat);
    m_axi_bvalid  = b_pend && (b_wait >= b_lat);
    m_axi_bresp   = m_axi_bvalid ? bresp_cfg : 2'b00;
  end

  always @(posedge clk) begin
    if (rst) begin
      aw_wait = 0; w_wait = 0; b_wait = 0;
      got_aw = 0; got_w = 0; b_pend = 0;
      aw_stall = 0; w_stall = 0;
    end else begin
      if (aw_stall && !(m_axi_awvalid && m_axi_awaddr == prev_awaddr)) viol++;
      if (w_stall && !(m_axi_wvalid && m_axi_wdata == prev_wdata)) viol++;
      aw_stall    = m_axi_awvalid && !m_axi_awready;
      w_stall     = m_axi_wvalid && !m_axi_wready;
      prev_awaddr = m_axi_awaddr;
      prev_wdata  = m_axi_wdata;
      if (m_axi_awvalid) awv_cycles++;
      if (done) done_cnt++;
      if (m_axi_awvalid && m_axi_awready) begin
        got_aw = 1; cap_addr = m_axi_awaddr; aw_hs++; aw_wait = 0;
      end else if (m_axi_awvalid) begin
        aw_wait++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        got_w = 1; cap_data = m_axi_wdata; w_hs++; w_wait = 0;
      end else if (m_axi_wvalid) begin
        w_wait++;
      end
      if (b_pend && m_axi_bvalid && m_axi_bready) begin
        mem[cap_addr] = cap_data[15:0];
        b_hs++; b_pend = 0; got_aw = 0; got_w = 0; b_wait = 0;
      end else if (b_pend) begin
        b_wait++;
      end else if (got_aw && got_w) begin
        b_pend = 1; b_wait = 0;
      end
    end
  end

  // Offers one record once the block is idle; returns #1 after the accepting edge.
  task automatic send(input logic [16:0] idx, input logic [15:0] w, input logic last,
                      input logic clr, input int al, input int wl, input int bl,
                      input logic [1:0] br);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_ready_timeout", 32'(s_ready), 32'd1);
    aw_lat = al; w_lat = wl; b_lat = bl; bresp_cfg = br;
    s_valid = 1'b1; s_index = idx; s_weight = w; s_last = last; clr_stats = clr;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; clr_stats = 1'b0;
    if (clr) begin
      exp_wr = 0;
      exp_err = 0;
    end
    if (32'(idx) >= NUM) begin
      if (!clr) exp_err++;
    end else begin
      exp_mem[32'(idx) * 4] = w;
      if (br == 2'b00) exp_wr++;
      else             exp_err++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_ready) chk("idle_timeout", 32'(s_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    int errs = 0;
    foreach (exp_mem[a]) begin
      if (!mem.exists(a) || mem[a] !== exp_mem[a]) errs++;
    end
    chk(tag, 32'(errs), 32'd0);
  endtask

  task automatic clear_stats();
    @(negedge clk);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    exp_wr = 0;
    exp_err = 0;
    chk("clr_write_count", 32'(write_count), 32'd0);
    chk("clr_err_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    int cyc, a0, w0, b0, d0, v0, r;
    logic [16:0] idx;
    logic [15:0] wt;
    logic [16:0] idxs [10];
    logic [15:0] wts [10];

    rst = 1'b1; s_valid = 1'b0; s_index = '0; s_weight = '0; s_last = 1'b0; clr_stats = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #7;
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_bready", 32'(m_axi_bready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_counts", {16'(write_count), 16'(err_count)}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single record, zero-wait slave
    send(17'd5, 16'hABCD, 1'b1, 1'b0, 0, 0, 0, 2'b00);
    chk("t1_awvalid", 32'(m_axi_awvalid), 32'd1);
    chk("t1_wvalid", 32'(m_axi_wvalid), 32'd1);
    chk("t1_awaddr", m_axi_awaddr, 32'h14);
    chk("t1_wdata", m_axi_wdata, 32'h0000ABCD);
    chk("t1_wstrb", 32'(m_axi_wstrb), 32'h3);
    chk("t1_busy", 32'(busy), 32'd1);
    cyc = 1;
    while (!s_ready && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t1_ready_latency", 32'(cyc), 32'd3);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_write_count", 32'(write_count), 32'(exp_wr));
    @(posedge clk);
    #1;
    chk("t1_done_pulse", 32'(done), 32'd0);

    // AW accepted one cycle before W
    a0 = aw_hs; w0 = w_hs;
    send(17'd100, 16'h1234, 1'b0, 1'b0, 0, 1, 0, 2'b00);
    @(posedge clk);
    #1;
    chk("t2a_aw_dropped", 32'(m_axi_awvalid), 32'd0);
    chk("t2a_w_held", 32'(m_axi_wvalid), 32'd1);
    @(posedge clk);
    #1;
    chk("t2a_w_dropped", 32'(m_axi_wvalid), 32'd0);
    chk("t2a_bready", 32'(m_axi_bready), 32'd1);
    wait_idle();
    chk("t2a_one_aw", 32'(aw_hs - a0), 32'd1);
    chk("t2a_one_w", 32'(w_hs - w0), 32'd1);

    // W accepted three cycles before AW
    a0 = aw_hs; w0 = w_hs;
    send(17'd101, 16'h5678, 1'b0, 1'b0, 3, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    chk("t2b_w_dropped", 32'(m_axi_wvalid), 32'd0);
    chk("t2b_aw_held", 32'(m_axi_awvalid), 32'd1);
    wait_idle();
    chk("t2b_one_aw", 32'(aw_hs - a0), 32'd1);
    chk("t2b_one_w", 32'(w_hs - w0), 32'd1);
    chk("t2_write_count", 32'(write_count), 32'(exp_wr));
    check_mem("t2_mem");

    // Out-of-range index is rejected locally; highest legal index still accepted
    v0 = awv_cycles;
    send(17'(NUM), 16'hDEAD, 1'b1, 1'b0, 0, 0, 0, 2'b00);
    chk("t3_err_count", 32'(err_count), 32'(exp_err));
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_stay_idle", 32'(s_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_no_awvalid", 32'(awv_cycles - v0), 32'd0);
    send(17'(NUM - 1), 16'h0F0F, 1'b0, 1'b0, 0, 0, 0, 2'b00);
    chk("t3_max_awaddr", m_axi_awaddr, (NUM - 1) * 4);
    wait_idle();

    // SLVERR response with delayed bvalid
    clear_stats();
    b0 = b_hs;
    send(17'd7, 16'h7777, 1'b0, 1'b0, 0, 0, 2, 2'b10);
    wait_idle();
    chk("t4_err_count", 32'(err_count), 32'd1);
    chk("t4_write_count", 32'(write_count), 32'd0);
    chk("t4_one_b", 32'(b_hs - b0), 32'd1);

    // Ten back-to-back records, random stalls
    clear_stats();
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      idxs[i] = 17'(1000 + i * 37);
      wts[i]  = 16'($urandom);
      send(idxs[i], wts[i], 1'(i == 9), 1'b0,
           int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 2'b00);
      if (i == 8) begin
        wait_idle();
        chk("t5_no_early_done", 32'(done_cnt - d0), 32'd0);
      end
    end
    wait_idle();
    chk("t5_write_count", 32'(write_count), 32'd10);
    chk("t5_done_once", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t5_readback", 32'(mem[32'(idxs[i]) * 4]), 32'(wts[i]));
    end

    // Random mix of rejects, response codes and clears
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(3, 0));
      idx = (r == 0) ? 17'(NUM + $urandom_range(999, 0)) : 17'($urandom_range(NUM - 1, 0));
      wt  = 16'($urandom);
      r   = int'($urandom_range(3, 0));
      send(idx, wt, 1'b0, 1'($urandom_range(19, 0) == 0),
           int'($urandom_range(4, 0)), int'($urandom_range(4, 0)), int'($urandom_range(2, 0)),
           (r < 2) ? 2'b00 : 2'(r));
    end
    wait_idle();
    chk("t6_write_count", 32'(write_count), 32'(exp_wr));
    chk("t6_err_count", 32'(err_count), 32'(exp_err));
    check_mem("t6_mem");

    // Clear coinciding with a reject increment: clear wins
    send(17'(NUM + 5), 16'h0, 1'b0, 1'b1, 0, 0, 0, 2'b00);
    chk("t7_clear_wins", 32'(err_count), 32'd0);

    // Asynchronous reset during ISSUE
    send(17'd20, 16'h2020, 1'b0, 1'b0, 6, 6, 0, 2'b00);
    chk("t8_awvalid_before", 32'(m_axi_awvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t8_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("t8_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_counts", {16'(write_count), 16'(err_count)}, 32'd0);
    exp_wr = 0; exp_err = 0;
    mem.delete();
    exp_mem.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(17'd21, 16'h2121, 1'b0, 1'b0, 0, 0, 0, 2'b00);
    wait_idle();
    chk("t8_after_write_count", 32'(write_count), 32'd1);
    check_mem("t8_mem");

    chk("valid_payload_stable", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
